// File: rtl/conv_win_ctrl_pkg.sv
// Shared types and default geometry for the 3x3 convolution window controller.
package conv_win_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 9;
    localparam int DEF_IMG_W = 28;
    localparam int DEF_IMG_H = 28;

endpackage

// File: rtl/conv_line_buf.sv
// Single-row delay line: dout is the sample written DEPTH enables ago.
// Contents are deliberately not reset; a frame rewrites them before use.
module conv_line_buf #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 28
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

    // Shift one position per accepted pixel.
    always_comb begin
        mem_d = mem_q;
        if (en) mem_d = {mem_q[DEPTH-2:0], din};
    end

    // Storage without reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_win_ctrl.sv
// Raster-stream to 3x3 window controller feeding the convolution unit.
// Optional CONV_WIN_STRIDE2_EN adds a stride2 input sampled at start; when set,
// windows are emitted only where (row-2) and (col-2) are both even.
module conv_win_ctrl
    import conv_win_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef CONV_WIN_STRIDE2_EN
    input  logic             stride2,
`endif
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [WIDTH-1:0] pix_in,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [WIDTH-1:0] w00, w01, w02,
    output logic [WIDTH-1:0] w10, w11, w12,
    output logic [WIDTH-1:0] w20, w21, w22,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    state_t                       state_q, state_d;
    logic [CW-1:0]                col_q, col_d;
    logic [RW-1:0]                row_q, row_d;
    logic                         win_valid_q, win_valid_d;
    logic                         last_pend_q, last_pend_d;
    logic [2:0][2:0][WIDTH-1:0]   win_q, win_d;
    logic [WIDTH-1:0]             lb0_out, lb1_out;
    logic                         acc, emit, is_last, stride_ok;

`ifdef CONV_WIN_STRIDE2_EN
    logic stride2_q, stride2_d;
    assign stride_ok = !stride2_q || (!row_q[0] && !col_q[0]);
`else
    assign stride_ok = 1'b1;
`endif

    // Stall intake while an un-taken window is pending or the last window drains.
    assign pix_ready = ((state_q == ST_FILL) || (state_q == ST_RUN)) && !last_pend_q
                       && !(win_valid_q && !win_ready);
    assign acc       = pix_valid && pix_ready;
    assign is_last   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign emit      = acc && (row_q >= ROW_TWO) && (col_q >= COL_TWO) && stride_ok;

    // Row N-1 and row N-2 delay lines.
    conv_line_buf #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb0 (
        .clk(clk), .en(acc), .din(pix_in), .dout(lb0_out)
    );
    conv_line_buf #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb1 (
        .clk(clk), .en(acc), .din(lb0_out), .dout(lb1_out)
    );

    // Next-state: FSM, raster counters, window valid and the 3x3 shift window.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        last_pend_d = last_pend_q;
        win_d       = win_q;
`ifdef CONV_WIN_STRIDE2_EN
        stride2_d   = stride2_q;
`endif
        // A new load keeps valid high; otherwise it drops once taken.
        win_valid_d = emit || (win_valid_q && !win_ready);

        if (acc) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb1_out;
            win_d[1][2] = lb0_out;
            win_d[2][2] = pix_in;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FILL;
                    col_d       = '0;
                    row_d       = '0;
                    last_pend_d = 1'b0;
`ifdef CONV_WIN_STRIDE2_EN
                    stride2_d   = stride2;
`endif
                end
            end
            ST_FILL, ST_RUN: begin
                if (acc) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (is_last) begin
                        // Finish only after the final window is taken, if there is one.
                        if (emit) begin
                            last_pend_d = 1'b1;
                            state_d     = ST_RUN;
                        end else begin
                            state_d     = ST_DONE;
                        end
                    end else if (state_q == ST_FILL && row_q == ROW_TWO && col_q == COL_TWO) begin
                        state_d = ST_RUN;
                    end
                end
                if (last_pend_q && win_valid_q && win_ready) begin
                    state_d     = ST_DONE;
                    last_pend_d = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and window registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            last_pend_q <= 1'b0;
            win_q       <= '0;
`ifdef CONV_WIN_STRIDE2_EN
            stride2_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            last_pend_q <= last_pend_d;
            win_q       <= win_d;
`ifdef CONV_WIN_STRIDE2_EN
            stride2_q   <= stride2_d;
`endif
        end
    end

    assign win_valid = win_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign w00 = win_q[0][0];
    assign w01 = win_q[0][1];
    assign w02 = win_q[0][2];
    assign w10 = win_q[1][0];
    assign w11 = win_q[1][1];
    assign w12 = win_q[1][2];
    assign w20 = win_q[2][0];
    assign w21 = win_q[2][1];
    assign w22 = win_q[2][2];

endmodule

// File: tb/tb_conv_win_ctrl.sv
// Directed bench for conv_win_ctrl on a 5x4 frame.
module tb_conv_win_ctrl;

    localparam int W  = 9;
    localparam int IW = 5;
    localparam int IH = 4;
    localparam int NWIN = (IW - 2) * (IH - 2);

    logic clk = 1'b0;
    logic rst_n, start, pix_valid, pix_ready, win_valid, win_ready, busy, done;
    logic [W-1:0] pix_in;
    logic [W-1:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
`ifdef CONV_WIN_STRIDE2_EN
    logic stride2 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int stall_cnt = 0;
    logic [9*W-1:0] wins[$];
    wire  [9*W-1:0] cur_win = {w00, w01, w02, w10, w11, w12, w20, w21, w22};

    conv_win_ctrl #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef CONV_WIN_STRIDE2_EN
        .stride2(stride2),
`endif
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_in(pix_in),
        .win_valid(win_valid), .win_ready(win_ready),
        .w00(w00), .w01(w01), .w02(w02),
        .w10(w10), .w11(w11), .w12(w12),
        .w20(w20), .w21(w21), .w22(w22),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Record every window handshake and every cycle with done high.
    always @(negedge clk) begin
        if (win_valid && win_ready) wins.push_back(cur_win);
        if (done) done_cnt++;
    end

    // Expected window whose newest pixel is at (r,c) in a frame of base+index pixels.
    function automatic logic [9*W-1:0] exp_win(input int base, input int r, input int c);
        logic [9*W-1:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v = {v[8*W-1:0], W'(base + (r - 2 + i) * IW + (c - 2 + j))};
        return v;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_pix(input int v, input bit with_start);
        int n;
        n = 0;
        pix_valid = 1'b1;
        pix_in = W'(v);
        if (with_start) start = 1'b1;
        @(negedge clk);
        while (!pix_ready && n < 200) begin
            n++;
            stall_cnt++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL send_pix_timeout pixel=%0d never accepted", v);
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic drive_frame(input int base, input int gap, input int start_at);
        for (int i = 0; i < IW * IH; i++) begin
            send_pix(base + i, i == start_at);
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_in = '0; win_ready = 1'b1;
        #12;
        checks++;
        if ({pix_ready, win_valid, busy, done} !== 4'b0000 || cur_win !== '0) begin
            errors++;
            $display("FAIL reset_state got pr/wv/busy/done=%b win=%h, want 0000 and 0",
                     {pix_ready, win_valid, busy, done}, cur_win);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        // Pixels offered in IDLE must not be taken.
        pix_valid = 1'b1; pix_in = W'(77);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pix_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore got pix_ready=%b busy=%b, want 0 0", pix_ready, busy);
            end
        end
        @(posedge clk); #1 pix_valid = 1'b0;
    endtask

    task automatic test_basic();
        wins.delete(); done_cnt = 0; stall_cnt = 0; win_ready = 1'b1;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_fill_state got busy=%b pix_ready=%b, want 1 1", busy, pix_ready);
        end
        drive_frame(0, 0, -1);
        wait_done();
        checks++;
        if (stall_cnt !== 0) begin
            errors++;
            $display("FAIL basic_throughput got %0d stall cycles, want 0", stall_cnt);
        end
        checks++;
        if (wins.size() != NWIN) begin
            errors++;
            $display("FAIL basic_count got %0d windows, want %0d", wins.size(), NWIN);
        end
        for (int k = 0; k < NWIN && k < wins.size(); k++) begin
            checks++;
            if (wins[k] !== exp_win(0, 2 + k / (IW - 2), 2 + k % (IW - 2))) begin
                errors++;
                $display("FAIL basic_win%0d got %h want %h", k, wins[k],
                         exp_win(0, 2 + k / (IW - 2), 2 + k % (IW - 2)));
            end
        end
        checks++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got done_cycles=%0d busy=%b, want 1 0", done_cnt, busy);
        end
    endtask

    task automatic test_backpressure();
        wins.delete(); done_cnt = 0; win_ready = 1'b0;
        pulse_start();
        fork
            drive_frame(0, 0, -1);
            begin
                logic [9*W-1:0] hold;
                int n;
                n = 0;
                while (!win_valid && n < 500) begin @(negedge clk); n++; end
                hold = cur_win;
                checks++;
                if (hold !== exp_win(0, 2, 2)) begin
                    errors++;
                    $display("FAIL bp_first_win got %h want %h", hold, exp_win(0, 2, 2));
                end
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (pix_ready !== 1'b0 || win_valid !== 1'b1 || cur_win !== hold) begin
                        errors++;
                        $display("FAIL bp_hold%0d got pr=%b wv=%b win=%h, want 0 1 %h",
                                 i, pix_ready, win_valid, cur_win, hold);
                    end
                    if (i < 2) @(negedge clk);
                end
                @(posedge clk); #1 win_ready = 1'b1;
            end
        join
        wait_done();
        checks++;
        if (wins.size() != NWIN) begin
            errors++;
            $display("FAIL bp_count got %0d windows, want %0d", wins.size(), NWIN);
        end
        for (int k = 0; k < NWIN && k < wins.size(); k++) begin
            checks++;
            if (wins[k] !== exp_win(0, 2 + k / (IW - 2), 2 + k % (IW - 2))) begin
                errors++;
                $display("FAIL bp_win%0d got %h want %h", k, wins[k],
                         exp_win(0, 2 + k / (IW - 2), 2 + k % (IW - 2)));
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL bp_done got %0d done cycles, want 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        wins.delete(); done_cnt = 0; win_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 9; i++) send_pix(i, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({pix_ready, win_valid, busy, done} !== 4'b0000 || cur_win !== '0) begin
            errors++;
            $display("FAIL midreset_state got pr/wv/busy/done=%b win=%h, want 0000 and 0",
                     {pix_ready, win_valid, busy, done}, cur_win);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (done_cnt !== 0 || wins.size() != 0) begin
            errors++;
            $display("FAIL midreset_abort got done_cycles=%0d windows=%0d, want 0 0",
                     done_cnt, wins.size());
        end
        pulse_start();
        drive_frame(100, 0, -1);
        wait_done();
        checks++;
        if (wins.size() != NWIN) begin
            errors++;
            $display("FAIL midreset_count got %0d windows, want %0d", wins.size(), NWIN);
        end
        for (int k = 0; k < NWIN && k < wins.size(); k++) begin
            checks++;
            if (wins[k] !== exp_win(100, 2 + k / (IW - 2), 2 + k % (IW - 2))) begin
                errors++;
                $display("FAIL midreset_win%0d got %h want %h", k, wins[k],
                         exp_win(100, 2 + k / (IW - 2), 2 + k % (IW - 2)));
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL midreset_done got %0d done cycles, want 1", done_cnt);
        end
    endtask

    task automatic test_start_in_run();
        wins.delete(); done_cnt = 0; win_ready = 1'b1;
        pulse_start();
        drive_frame(0, 0, 15);
        wait_done();
        checks++;
        if (wins.size() != NWIN) begin
            errors++;
            $display("FAIL startrun_count got %0d windows, want %0d", wins.size(), NWIN);
        end
        for (int k = 0; k < NWIN && k < wins.size(); k++) begin
            checks++;
            if (wins[k] !== exp_win(0, 2 + k / (IW - 2), 2 + k % (IW - 2))) begin
                errors++;
                $display("FAIL startrun_win%0d got %h want %h", k, wins[k],
                         exp_win(0, 2 + k / (IW - 2), 2 + k % (IW - 2)));
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL startrun_done got %0d done cycles, want 1", done_cnt);
        end
    endtask

    task automatic test_toggle_valid();
        wins.delete(); done_cnt = 0; win_ready = 1'b1;
        pulse_start();
        drive_frame(0, 1, -1);
        wait_done();
        checks++;
        if (wins.size() != NWIN) begin
            errors++;
            $display("FAIL toggle_count got %0d windows, want %0d", wins.size(), NWIN);
        end
        for (int k = 0; k < NWIN && k < wins.size(); k++) begin
            checks++;
            if (wins[k] !== exp_win(0, 2 + k / (IW - 2), 2 + k % (IW - 2))) begin
                errors++;
                $display("FAIL toggle_win%0d got %h want %h", k, wins[k],
                         exp_win(0, 2 + k / (IW - 2), 2 + k % (IW - 2)));
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL toggle_done got %0d done cycles, want 1", done_cnt);
        end
    endtask

`ifdef CONV_WIN_STRIDE2_EN
    task automatic test_stride2();
        wins.delete(); done_cnt = 0; win_ready = 1'b1;
        stride2 = 1'b1;
        pulse_start();
        stride2 = 1'b0;
        drive_frame(0, 0, -1);
        wait_done();
        checks++;
        if (wins.size() != 2) begin
            errors++;
            $display("FAIL stride2_count got %0d windows, want 2", wins.size());
        end
        if (wins.size() >= 2) begin
            checks++;
            if (wins[0] !== exp_win(0, 2, 2) || wins[1] !== exp_win(0, 2, 4)) begin
                errors++;
                $display("FAIL stride2_wins got %h %h want %h %h", wins[0], wins[1],
                         exp_win(0, 2, 2), exp_win(0, 2, 4));
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL stride2_done got %0d done cycles, want 1", done_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_frame();
        test_start_in_run();
        test_toggle_valid();
`ifdef CONV_WIN_STRIDE2_EN
        test_stride2();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
